// File: rtl/output_module.sv
// output_module: packs the 32-bit sorted elements from the merge tree tail into
// 512-bit blocks (lane 0 = first element in time) and buffers them in a small FIFO.
// Optional macro PAD_FLUSH_EN adds a flush port that pushes a partial block padded with all-ones.

// output_fifo: DEPTH-entry block FIFO, head presented combinationally from storage.
// Latency: a pushed word is visible at head_o the cycle after the push edge when empty.
// Backpressure: full_o from registered occupancy only; pushes while full are dropped, pops while empty ignored.
module output_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         vld_o,
  output logic         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          push_ok;
  logic          pop_ok;

  assign vld_o   = (occ_q != '0);
  assign full_o  = (occ_q == OW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && vld_o;

  // Next-state for pointers and occupancy; a simultaneous push and pop leaves occupancy alone.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Block storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// output_module: element-to-block deserializer feeding the write-back path.
// Latency: dout_valid rises the cycle after the 16th accepted element (FIFO empty).
// Backpressure: full = FIFO at DEPTH; elements offered while full are ignored and must be held.
module output_module #(
  parameter int ELEM_W = 32,
  parameter int ELEMS  = 16,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ELEM_W-1:0]         din,
  input  logic                      din_valid,
  output logic                      full,
  output logic [ELEM_W*ELEMS-1:0]   dout,
  output logic                      dout_valid,
  input  logic                      dout_deq,
  output logic [15:0]               blk_cnt
`ifdef PAD_FLUSH_EN
  ,
  input  logic                      flush
`endif
);

  localparam int BW = ELEM_W * ELEMS;
  localparam int CW = $clog2(ELEMS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] asm_q, asm_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;

  logic          acc;
  logic          last_lane;
  logic          complete;
  logic          push;
  logic [BW-1:0] asm_shift;
  logic [BW-1:0] push_dat;

  logic          fifo_full;
  logic          fifo_vld;
  logic [BW-1:0] fifo_head;

  // full comes from registered occupancy, so a same-cycle dequeue never opens the door early.
  assign acc       = din_valid && !fifo_full;
  // New elements enter at the top lane and slide down; after a full run the first one is in lane 0.
  assign asm_shift = {din, asm_q[BW-1:ELEM_W]};
  assign last_lane = (cnt_q == CW'(ELEMS - 1));
  assign complete  = acc && last_lane;

`ifdef PAD_FLUSH_EN
  logic          flush_fire;
  logic [CW:0]   fill;
  logic [BW-1:0] pad_base;
  logic [BW-1:0] pad_dat;

  // A flush that coincides with the 16th element is just a normal completion.
  assign flush_fire = flush && !fifo_full && ((cnt_q != '0) || acc) && !complete;
  assign fill       = {1'b0, cnt_q} + {{CW{1'b0}}, acc};
  assign pad_base   = acc ? asm_shift : asm_q;
  // The filled lanes occupy the top of the assembly word; shift them down to lane 0
  // and let all-ones fill the vacated upper lanes so ascending order is kept.
  assign pad_dat    = BW'({{BW{1'b1}}, pad_base} >> ((ELEMS - int'(fill)) * ELEM_W));
  assign push       = complete || flush_fire;
  assign push_dat   = complete ? asm_shift : pad_dat;
`else
  assign push       = complete;
  assign push_dat   = asm_shift;
`endif

  // Assembly, lane counter and block counter next-state.
  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    blk_cnt_d = blk_cnt_q;
    if (acc) begin
      asm_d = asm_shift;
      cnt_d = cnt_q + CW'(1);
    end
    if (push) begin
      cnt_d     = '0;
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  // Assembly state registers; reset discards any partial block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      asm_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  output_fifo #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (dout_deq),
    .head_o     (fifo_head),
    .vld_o      (fifo_vld),
    .full_o     (fifo_full)
  );

  assign full       = fifo_full;
  assign dout       = fifo_head;
  assign dout_valid = fifo_vld;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_output_module.sv
// Testbench for output_module: directed scenarios plus randomized traffic checked
// against a queue-based reference model (partial-element list + block queue).
`timescale 1ns/1ps
module tb_output_module;

  localparam int EW = 32;
  localparam int NE = 16;
  localparam int DP = 2;
  localparam int BW = EW * NE;
`ifdef PAD_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [EW-1:0] din;
  logic          din_valid;
  logic          full;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          dout_deq;
  logic [15:0]   blk_cnt;
`ifdef PAD_FLUSH_EN
  logic          flush;
`endif

  always #5 clk = ~clk;

  output_module #(.ELEM_W(EW), .ELEMS(NE), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .full       (full),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_deq   (dout_deq),
    .blk_cnt    (blk_cnt)
`ifdef PAD_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: elements of the block being assembled, and queued blocks.
  logic [EW-1:0] part_q [$];
  logic [BW-1:0] blk_q  [$];
  int unsigned   m_blk = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane k of a block is the k-th element in arrival order; missing lanes are all-ones.
  task automatic emit_block();
    logic [BW-1:0] b;
    b = '1;
    for (int k = 0; k < part_q.size(); k++) b[k*EW +: EW] = part_q[k];
    blk_q.push_back(b);
    part_q.delete();
    m_blk++;
  endtask

  task automatic model_step(input logic v, input logic [EW-1:0] d, input logic deq, input logic fl);
    bit was_full;
    bit acc;
    was_full = (blk_q.size() == DP);
    acc      = v && !was_full;
    if (deq && blk_q.size() != 0) void'(blk_q.pop_front());
    if (acc) part_q.push_back(d);
    if (part_q.size() == NE) emit_block();
    else if (HAS_FLUSH && fl && !was_full && part_q.size() != 0) emit_block();
  endtask

  task automatic compare(input string where);
    check({where, ".full"},  full,       blk_q.size() == DP);
    check({where, ".valid"}, dout_valid, blk_q.size() != 0);
    check({where, ".blk"},   blk_cnt,    m_blk[15:0]);
    if (blk_q.size() != 0) check({where, ".dout"}, dout, blk_q[0]);
  endtask

  // Called at a negedge: drive, clock, update model, then compare at the next negedge.
  task automatic cycle(input logic v, input logic [EW-1:0] d, input logic deq, input logic fl, input string where);
    din_valid = v;
    din       = d;
    dout_deq  = deq;
`ifdef PAD_FLUSH_EN
    flush     = fl;
`endif
    @(posedge clk);
    model_step(v, d, deq, fl);
    @(negedge clk);
    din_valid = 1'b0;
    dout_deq  = 1'b0;
`ifdef PAD_FLUSH_EN
    flush     = 1'b0;
`endif
    compare(where);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    dout_deq  = 1'b0;
`ifdef PAD_FLUSH_EN
    flush     = 1'b0;
`endif
    #2;
    check("rst.valid", dout_valid, 1'b0);
    check("rst.full",  full,       1'b0);
    check("rst.blk",   blk_cnt,    16'd0);
    check("rst.dout",  dout,       '0);
    part_q.delete();
    blk_q.delete();
    m_blk = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
  endtask

  initial begin
    int unsigned exp_blk;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    dout_deq  = 1'b0;
`ifdef PAD_FLUSH_EN
    flush     = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // 16 elements 1..16, no dequeue.
    for (int i = 1; i <= 16; i++) cycle(1'b1, EW'(i), 1'b0, 1'b0, "t1");
    check("t1.lane0",  dout[31:0],    32'd1);
    check("t1.lane15", dout[511:480], 32'd16);
    check("t1.blk",    blk_cnt,       16'd1);

    // Fill the FIFO, hold element 33 while full, then a single dequeue.
    for (int i = 17; i <= 32; i++) cycle(1'b1, EW'(i), 1'b0, 1'b0, "t2f");
    check("t2.full", full, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd33, 1'b0, 1'b0, "t2hold");
    cycle(1'b1, 32'd33, 1'b1, 1'b0, "t2deq");
    check("t2.full_drop", full, 1'b0);
    for (int i = 33; i <= 48; i++) cycle(1'b1, EW'(i), 1'b0, 1'b0, "t2b");
    cycle(1'b0, '0, 1'b1, 1'b0, "t2pop");
    check("t2.lane0_33", dout[31:0], 32'd33);
    drain();

    // 160 back-to-back elements, dequeue whenever a block is waiting.
    exp_blk = m_blk + 10;
    for (int i = 0; i < 160; i++)
      cycle(1'b1, $urandom, blk_q.size() != 0, 1'b0, "t3");
    check("t3.blk", blk_cnt, exp_blk[15:0]);
    drain();

    // Push and dequeue in the same cycle with one block queued.
    for (int i = 0; i < 31; i++) cycle(1'b1, 32'h4000_0000 + EW'(i), 1'b0, 1'b0, "t4");
    cycle(1'b1, 32'h4000_001F, 1'b1, 1'b0, "t4pd");
    check("t4.full",  full,       1'b0);
    check("t4.valid", dout_valid, 1'b1);
    check("t4.head",  dout[31:0], 32'h4000_0010);
    cycle(1'b0, '0, 1'b1, 1'b0, "t4pop");
    check("t4.empty", dout_valid, 1'b0);

    // Reset in the middle of a block.
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'hDEAD_0000 + EW'(i), 1'b0, 1'b0, "t5a");
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h5000_0000 + EW'(i), 1'b0, 1'b0, "t5b");
    check("t5.lane0", dout[31:0],    32'h5000_0000);
    check("t5.lane15", dout[511:480], 32'h5000_000F);
    check("t5.blk",   blk_cnt,       16'd1);
    drain();

`ifdef PAD_FLUSH_EN
    // Partial block flush with padding, then flush coinciding with the 16th element.
    for (int i = 10; i <= 14; i++) cycle(1'b1, EW'(i), 1'b0, 1'b0, "t6a");
    cycle(1'b0, '0, 1'b0, 1'b1, "t6fl");
    check("t6.lane4", dout[159:128], 32'd14);
    check("t6.lane5", dout[191:160], 32'hFFFF_FFFF);
    check("t6.lane15", dout[511:480], 32'hFFFF_FFFF);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1, "t6noop");
    for (int i = 0; i < 15; i++) cycle(1'b1, 32'h6000_0000 + EW'(i), 1'b0, 1'b0, "t6b");
    exp_blk = m_blk + 1;
    cycle(1'b1, 32'h6000_000F, 1'b0, 1'b1, "t6c");
    check("t6.single",  blk_cnt,       exp_blk[15:0]);
    check("t6.nopad",   dout[511:480], 32'h6000_000F);
    drain();
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0,
            HAS_FLUSH && (($urandom % 20) == 0), "rnd");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/output_module.md
Name: output_module

Overview:
- Deserializer at the tail of the merge sorter tree: collects the 32-bit sorted elements the tree emits, one per cycle, and packs each run of 16 into a 512-bit block for the write-back path.
- This is the mirror of the block-to-element serializer at the tree input, and uses the same lane order: lane 0 (bits [31:0]) is the first element in time.
- A small internal FIFO of packed blocks decouples the tree from write-back stalls.
- Back-pressure runs upstream to the tree via `full`.

Parameters:
- ELEM_W, 32: element width in bits.
- ELEMS, 16: elements per block. Block width = ELEM_W*ELEMS = 512.
- DEPTH, 2: packed-block FIFO entries (power of 2, >= 2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-high.
- din  input  ELEM_W  element from the merge tree.
- din_valid  input  1  element enqueue request.
- full  output  1  module cannot accept an element this cycle.
- dout  output  ELEM_W*ELEMS  head block of the FIFO.
- dout_valid  output  1  FIFO not empty.
- dout_deq  input  1  downstream consumes the head block at this edge.
- blk_cnt  output  16  number of blocks pushed into the FIFO; wraps modulo 2^16.
- flush  input  1  present only with PAD_FLUSH_EN.

Behaviour:
- Reset: all of the following clear asynchronously to 0.
  - lane counter cnt (4 bits)
  - assembly register asm
  - FIFO read pointer, write pointer and occupancy
  - blk_cnt
  - Resulting outputs: dout_valid=0, full=0, dout=0.
  - Reset mid-block discards any partial block and all FIFO contents.
- Accept condition: acc = din_valid && !full.
  - din_valid while full is ignored: no state change and the element is lost. The producer must hold it.
- Packing on acc:
  - asm <= {din, asm[511:32]}.
  - cnt <= cnt+1, wrapping 15->0.
  - After 16 accepts, element k (k=0..15, in arrival order) sits in bits [32k+31:32k].
- Block completion: on acc with cnt==15, the word {din, asm[511:32]} is written into the FIFO at the same edge. asm is not used again until refilled.
  - blk_cnt increments at that edge.
  - Latency: dout_valid is high in the cycle after the 16th accepted element (assuming the FIFO was empty).
- full = (occupancy == DEPTH); it is combinational from registered occupancy only.
  - A same-cycle dout_deq does not lower full. This is a conservative rule that keeps the path short.
  - When full, the 16th element cannot arrive, so no push is ever lost.
- FIFO:
  - dout = mem[rd_ptr], dout_valid = (occupancy != 0).
  - On dout_deq && dout_valid: rd_ptr advances (wrapping at DEPTH) and occupancy decrements.
  - dout_deq while empty is ignored.
  - Simultaneous push and deq: occupancy is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Throughput: one element per cycle sustained when downstream deqs at least once every 16 cycles.
- No combinational path from din to dout. dout_valid depends only on registers.

Optional Feature:
- PAD_FLUSH_EN: when defined, the flush port exists.
- Flush condition: on flush && !full && (cnt!=0 || acc), the current partial block is pushed to the FIFO.
  - Any element accepted in the same cycle is included first.
  - Unfilled upper lanes are padded with all-ones (32'hFFFFFFFF), so ascending order is preserved.
  - cnt <= 0 and blk_cnt increments.
- If flush arrives with cnt==15 and acc, this is a normal completion: no padding and a single push.
- flush with cnt==0 and no acc is a no-op.
- flush while full is ignored and must be held by the producer.
- When PAD_FLUSH_EN is not defined: no flush port, and partial blocks stay in asm indefinitely.

Test Plan:
- Reset, then 16 consecutive elements 1..16 with dout_deq=0 -> dout_valid rises one cycle after the 16th accept; dout[31:0]=1, dout[511:480]=16; blk_cnt=1.
- 48 elements with dout_deq held 0 (DEPTH=2) -> full=1 after the 32nd accept; elements 33.. are ignored while held; single dout_deq -> full drops next cycle, and the held element 33 is then accepted into lane 0.
- Continuous 1-per-cycle input for 160 elements, dout_deq pulsed whenever dout_valid -> 10 blocks, no full assertion, each lane sequence matches the input order, blk_cnt=10.
- Push and deq in the same cycle with occupancy 1 -> occupancy stays 1, new head correct, full stays 0.
- Assert rst after 7 elements of a block -> dout_valid=0, blk_cnt=0; the next 16 elements form a block starting at lane 0 with no stale data.
- PAD_FLUSH_EN: 5 elements 10..14 then flush -> one block with lanes 0-4 = 10..14 and lanes 5-15 = 32'hFFFFFFFF; cnt=0. A flush with 16th element and acc -> single unpadded block.
